fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-address and PC width.
REQ-002 SHALL have parameter INSTR_W, default 8, meaning instruction width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Read_Address, output, ADDR_W, current PC driven to the combinational instruction memory.
REQ-006 SHALL have port Instruction, input, INSTR_W, instruction memory word at Read_Address, same cycle.
REQ-007 SHALL have port Stall, input, 1, downstream hold request.
REQ-008 SHALL have port Redirect_Valid, input, 1, downstream PC override strobe.
REQ-009 SHALL have port Redirect_Addr, input, ADDR_W, override target.
REQ-010 SHALL have port Instr_Out, output, INSTR_W, registered IF/ID instruction.
REQ-011 SHALL have port PC_Out, output, ADDR_W, registered address of Instr_Out.
REQ-012 SHALL have port Valid_Out, output, 1, Instr_Out/PC_Out hold a real fetch.
REQ-013 SHALL have port Halted, output, 1, self-loop jump detected; fetch frozen.
REQ-014 SHALL have port Fetch_Count, output, 8, number of valid fetches since reset.

Function
REQ-015 SHALL decode opcode as Instruction[7:6]; 2'b11 is jump, all others sequential.
REQ-016 SHALL compute next PC as PC+1 for non-jumps and PC + sign-extend(Instruction[5:0]) for jumps, modulo 2^ADDR_W; 8'hFF+1 wraps to 8'h00.
REQ-017 SHALL, in a normal cycle (no Redirect_Valid, no Stall, not Halted), load Instr_Out<=Instruction, PC_Out<=PC, Valid_Out<=1, PC<=next PC, Fetch_Count<=Fetch_Count+1 (wraps at 255->0).
REQ-018 SHALL forward jump instructions to Instr_Out with Valid_Out=1; the jump takes effect with zero bubble cycles.
REQ-019 SHALL, when Stall=1 and Redirect_Valid=0, hold PC, Instr_Out, PC_Out, Valid_Out and Fetch_Count.
REQ-020 SHALL, when Redirect_Valid=1, load PC<=Redirect_Addr, Valid_Out<=0, clear Halted, leave Fetch_Count unchanged, regardless of Stall.
REQ-021 SHALL set Halted when a jump with offset 6'b000000 is fetched in a normal cycle; that jump is still delivered once (Valid_Out=1, counted), PC stays unchanged.
REQ-022 SHALL, while Halted=1 and no Redirect_Valid, hold PC, drive Valid_Out<=0 every cycle, and not increment Fetch_Count.
REQ-023 SHALL apply priority Reset > Redirect_Valid > Stall > Halted > normal.
REQ-024 SHALL drive Read_Address directly from the PC register (no combinational path from Instruction).

Reset
REQ-025 SHALL, on Reset=1, asynchronously set PC=0, Instr_Out=0, PC_Out=0, Valid_Out=0, Halted=0, Fetch_Count=0.
REQ-026 SHALL resume with a normal fetch of address 0 on the first rising edge after Reset deasserts; reset mid-stall or mid-halt discards all state.

Structure
REQ-027 SHALL take opcode constants (ADD=00, LW=01, SW=10, J=11), ADDR_W and INSTR_W from the shared CPU package.
REQ-028 SHALL contain one sub-module, next_pc_logic, combinational: PC + Instruction -> next PC, is_jump, is_self_loop.

Verification
REQ-029 SHALL verify reset: hold Reset mid-run -> all outputs 0 asynchronously; after release, Read_Address=0 then 1 on consecutive cycles.
REQ-030 SHALL verify sequential fetch: memory lw/lw/add/sw at 0..3 -> PC_Out 0,1,2,3 with Valid_Out=1, Fetch_Count=4.
REQ-031 SHALL verify jump: 8'b11_111110 at address 4 -> next Read_Address=2, no bubble; 8'b11_000010 at 4 -> 6.
REQ-032 SHALL verify stall vs redirect: Stall=1 for 3 cycles -> outputs frozen; Stall=1 with Redirect_Valid=1, Redirect_Addr=8'h40 -> PC=8'h40, Valid_Out=0.
REQ-033 SHALL verify halt: 8'b11_000000 at 5 -> one Valid_Out=1 with PC_Out=5, then Halted=1, Valid_Out=0, Fetch_Count frozen until redirect clears it.
REQ-034 SHALL verify wrap: PC=8'hFF non-jump -> next PC 8'h00; Fetch_Count 255 -> 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: datapath widths, opcode encoding and fetch state.
package fetch_unit_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 8;

  typedef enum logic [1:0] {
    OPC_ADD = 2'b00,
    OPC_LW  = 2'b01,
    OPC_SW  = 2'b10,
    OPC_J   = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic opcode_e get_opcode(input logic [7:0] instr);
    return opcode_e'(instr[7:6]);
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC: PC+1 for sequential ops, PC+sext(offset) for jumps.
module next_pc_logic
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  next_pc_o,
  output logic               is_jump_o,
  output logic               is_self_loop_o
);

  logic [ADDR_W-1:0] offset_ext;

  assign offset_ext     = {{(ADDR_W-6){instr_i[5]}}, instr_i[5:0]};
  assign is_jump_o      = (get_opcode(instr_i[7:0]) == OPC_J);
  assign is_self_loop_o = is_jump_o && (instr_i[5:0] == 6'b000000);
  // Addition is modulo 2^ADDR_W, so 8'hFF + 1 wraps to 8'h00.
  assign next_pc_o      = is_jump_o ? (pc_i + offset_ext) : (pc_i + {{(ADDR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID output register, halt-on-self-loop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  Read_Address,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Stall,
  input  logic               Redirect_Valid,
  input  logic [ADDR_W-1:0]  Redirect_Addr,
  output logic [INSTR_W-1:0] Instr_Out,
  output logic [ADDR_W-1:0]  PC_Out,
  output logic               Valid_Out,
  output logic               Halted,
  output logic [7:0]         Fetch_Count
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_out_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic [7:0]         count_q;
  fetch_state_e       state_q;

  logic [ADDR_W-1:0]  next_pc;
  logic               is_jump;
  logic               is_self_loop;

  next_pc_logic #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .pc_i           (pc_q),
    .instr_i        (Instruction),
    .next_pc_o      (next_pc),
    .is_jump_o      (is_jump),
    .is_self_loop_o (is_self_loop)
  );

  // Priority: Reset > Redirect_Valid > Stall > halted > normal fetch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q     <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      count_q  <= 8'd0;
      state_q  <= ST_RUN;
    end else if (Redirect_Valid) begin
      pc_q    <= Redirect_Addr;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
    end else if (!Stall) begin
      case (state_q)
        ST_HALT: valid_q <= 1'b0;
        default: begin
          instr_q  <= Instruction;
          pc_out_q <= pc_q;
          valid_q  <= 1'b1;
          count_q  <= count_q + 8'd1;
          // A self-loop jump is delivered once, then fetch freezes on it.
          if (is_jump && is_self_loop) state_q <= ST_HALT;
          else                         pc_q    <= next_pc;
        end
      endcase
    end
  end

  assign Read_Address = pc_q;
  assign Instr_Out    = instr_q;
  assign PC_Out       = pc_out_q;
  assign Valid_Out    = valid_q;
  assign Halted       = (state_q == ST_HALT);
  assign Fetch_Count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural PC model with a fetch scoreboard plus directed checks.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  logic [7:0] Read_Address;
  logic [7:0] Instruction;
  logic       Stall;
  logic       Redirect_Valid;
  logic [7:0] Redirect_Addr;
  logic [7:0] Instr_Out;
  logic [7:0] PC_Out;
  logic       Valid_Out;
  logic       Halted;
  logic [7:0] Fetch_Count;

  logic [7:0] mem [256];
  logic [15:0] exp_q [$];

  logic [7:0] m_pc, m_pout, m_iout, m_cnt;
  logic       m_valid, m_halt;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(8)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Read_Address   (Read_Address),
    .Instruction    (Instruction),
    .Stall          (Stall),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_Addr  (Redirect_Addr),
    .Instr_Out      (Instr_Out),
    .PC_Out         (PC_Out),
    .Valid_Out      (Valid_Out),
    .Halted         (Halted),
    .Fetch_Count    (Fetch_Count)
  );

  assign Instruction = mem[Read_Address];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_pout = 8'd0; m_iout = 8'd0; m_cnt = 8'd0;
    m_valid = 1'b0; m_halt = 1'b0;
    exp_q.delete();
  endtask

  // One clock: update the model from the inputs, then compare after the edge.
  task automatic step();
    logic [7:0]  ins;
    logic [15:0] e;
    int          off;
    logic        fetched;
    fetched = 1'b0;
    if (Redirect_Valid) begin
      m_pc = Redirect_Addr; m_valid = 1'b0; m_halt = 1'b0;
    end else if (Stall) begin
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else begin
      ins = mem[m_pc];
      exp_q.push_back({m_pc, ins});
      fetched = 1'b1;
      m_pout = m_pc; m_iout = ins; m_valid = 1'b1; m_cnt = m_cnt + 8'd1;
      if (ins[7:6] == 2'b11) begin
        off = int'(ins[5:0]);
        if (off > 31) off = off - 64;
        if (off == 0) m_halt = 1'b1;
        else m_pc = 8'((int'(m_pc) + off + 256) % 256);
      end else begin
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
    @(posedge Clk); #1;
    chk("read_addr", Read_Address, m_pc);
    chk("valid_out", Valid_Out, m_valid);
    chk("halted", Halted, m_halt);
    chk("fetch_count", Fetch_Count, m_cnt);
    if (fetched) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_pc_out", PC_Out, e[15:8]);
        chk("sb_instr_out", Instr_Out, e[7:0]);
      end
    end else begin
      chk("hold_pc_out", PC_Out, m_pout);
      chk("hold_instr_out", Instr_Out, m_iout);
    end
  endtask

  // Assert reset between edges, check asynchronous clear, release mid-cycle.
  task automatic do_reset();
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_read_addr", Read_Address, 0);
    chk("rst_instr_out", Instr_Out, 0);
    chk("rst_pc_out", PC_Out, 0);
    chk("rst_valid", Valid_Out, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_count", Fetch_Count, 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    chk("rst_release_ra", Read_Address, 0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect_Valid = 1'b0; Redirect_Addr = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h03; mem[3] = 8'h84;
    mem[4] = 8'hFE;
    model_reset();
    do_reset();

    // Sequential fetch lw/lw/add/sw.
    step();
    chk("first_ra", Read_Address, 1);
    chk("first_pc_out", PC_Out, 0);
    step(); step(); step();
    chk("seq_pc_out3", PC_Out, 3);
    chk("seq_valid", Valid_Out, 1);
    chk("seq_count4", Fetch_Count, 4);

    // Backward jump from 4 to 2, no bubble.
    step();
    chk("jb_ra", Read_Address, 2);
    chk("jb_pc_out", PC_Out, 4);
    chk("jb_instr", Instr_Out, 8'hFE);
    step();
    chk("jb_no_bubble", Valid_Out, 1);
    chk("jb_pc_out2", PC_Out, 2);

    // Forward jump from 4 to 6.
    mem[4] = 8'hC2;
    Redirect_Valid = 1'b1; Redirect_Addr = 8'h04;
    step();
    Redirect_Valid = 1'b0;
    chk("redir_valid", Valid_Out, 0);
    chk("redir_count", Fetch_Count, 6);
    step();
    chk("jf_ra", Read_Address, 6);
    chk("jf_pc_out", PC_Out, 4);

    // Stall freezes everything; redirect overrides stall.
    Stall = 1'b1;
    repeat (3) step();
    chk("stall_ra", Read_Address, 6);
    chk("stall_pc_out", PC_Out, 4);
    chk("stall_instr", Instr_Out, 8'hC2);
    chk("stall_valid", Valid_Out, 1);
    chk("stall_count", Fetch_Count, 7);
    Redirect_Valid = 1'b1; Redirect_Addr = 8'h40;
    step();
    chk("stall_redir_ra", Read_Address, 8'h40);
    chk("stall_redir_valid", Valid_Out, 0);
    chk("stall_redir_count", Fetch_Count, 7);
    Redirect_Valid = 1'b0; Stall = 1'b0;

    // Self-loop halt at 5.
    mem[5] = 8'hC0;
    Redirect_Valid = 1'b1; Redirect_Addr = 8'h05;
    step();
    Redirect_Valid = 1'b0;
    step();
    chk("halt_valid_once", Valid_Out, 1);
    chk("halt_pc_out", PC_Out, 5);
    chk("halt_flag", Halted, 1);
    chk("halt_count", Fetch_Count, 8);
    repeat (2) step();
    chk("halted_valid", Valid_Out, 0);
    chk("halted_ra", Read_Address, 5);
    chk("halted_count", Fetch_Count, 8);
    Redirect_Valid = 1'b1; Redirect_Addr = 8'hFE;
    step();
    Redirect_Valid = 1'b0;
    chk("unhalt", Halted, 0);

    // PC wrap FF -> 00.
    step(); step();
    chk("wrap_pc_out", PC_Out, 8'hFF);
    chk("wrap_ra", Read_Address, 8'h00);
    chk("wrap_count", Fetch_Count, 10);

    // Random program with random stalls and redirects.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 300; i++) begin
      Stall          = ($urandom_range(0, 3) == 0);
      Redirect_Valid = ($urandom_range(0, 9) == 0);
      Redirect_Addr  = 8'($urandom_range(0, 255));
      step();
    end
    Stall = 1'b0; Redirect_Valid = 1'b0;

    // Drive Fetch_Count to 255 and across the wrap.
    for (int i = 0; i < 700 && m_cnt != 8'd255; i++) begin
      Redirect_Valid = m_halt;
      Redirect_Addr  = 8'($urandom_range(0, 255));
      step();
    end
    Redirect_Valid = 1'b0;
    chk("count_255", Fetch_Count, 255);
    if (m_halt) begin
      Redirect_Valid = 1'b1; Redirect_Addr = 8'h10;
      step();
      Redirect_Valid = 1'b0;
    end
    step();
    chk("count_wrap0", Fetch_Count, 0);

    // Reset in the middle of a stall discards all state.
    mem[0] = 8'h00;
    Stall = 1'b1;
    step();
    do_reset();
    Stall = 1'b0;
    step();
    chk("post_rst_ra", Read_Address, 1);
    chk("post_rst_pc_out", PC_Out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
